// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: prefix bytes, receive
// FSM states and the buffered key-event record.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO for decoded key events; drops a push when full
// unless a pop happens in the same cycle, and flags the drop.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  ps2_event_t wr_data,
    input  logic       pop,
    output ps2_event_t rd_data,
    output logic       valid,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ps2_event_t    mem [FIFO_DEPTH];
    ps2_event_t    last_head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // NOTE: storage has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= push && full && !pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_head <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // While empty, present the entry most recently consumed.
    assign rd_data = empty ? last_head : mem[rd_ptr];
    assign valid   = !empty;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames,
// folds E0/F0 prefixes into event flags and queues events for the consumer.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       out_break,
    output logic       out_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_prev;
    logic          fall;
    logic          bit_in;
    ps2_state_e    state;
    ps2_state_e    next_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_ok;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
    logic          ext_flag;
    logic          brk_flag;
    logic          accept;
    logic          err_now;
    logic          push;
    ps2_event_t    head;

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_prev <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], PS2C};
            d_sync <= {d_sync[0], PS2D};
            c_prev <= c_sync[1];
        end
    end

    assign fall    = c_prev && !c_sync[1];
    assign bit_in  = d_sync[1];
    assign timeout = (state != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        err_now    = 1'b0;
        if (timeout) begin
            next_state = ST_IDLE;
            err_now    = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE:   if (!bit_in) next_state = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) next_state = ST_PARITY;
                ST_PARITY: next_state = ST_STOP;
                ST_STOP: begin
                    next_state = ST_IDLE;
                    if (bit_in && parity_ok) accept  = 1'b1;
                    else                     err_now = 1'b1;
                end
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            parity_ok <= 1'b0;
            tmo_cnt   <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_now;
            if (state == ST_IDLE || fall || timeout) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_cnt + TW'(1);
            if (fall && state == ST_IDLE) bit_cnt <= '0;
            if (fall && state == ST_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {bit_in, shift[7:1]};
            end
            if (fall && state == ST_PARITY) parity_ok <= odd_parity_ok(shift, bit_in);
            if (err_now) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (accept) begin
                if (shift == PS2_PREFIX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift == PS2_PREFIX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

    assign push = accept && (shift != PS2_PREFIX_EXT) && (shift != PS2_PREFIX_BRK);

    ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_data  ('{ext: ext_flag, brk: brk_flag, code: shift}),
        .pop      (out_ready),
        .rd_data  (head),
        .valid    (out_valid),
        .overflow (overflow)
    );

    assign out_code  = head.code;
    assign out_break = head.brk;
    assign out_ext   = head.ext;

endmodule
